// File: rtl/pong_pkg.sv
// Shared types for the pong paddle tracker: coordinate width, box record and FSM state.
package pong_pkg;
  localparam int COORD_W = 13;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t top;
    coord_t bot;
    coord_t left;
    coord_t right;
  } bbox_t;

  // Mins start at all ones and maxes at zero so the first hit always wins both compares.
  localparam bbox_t BBOX_CLEAR = {{COORD_W{1'b1}}, {COORD_W{1'b0}},
                                  {COORD_W{1'b1}}, {COORD_W{1'b0}}};

  typedef enum logic {
    ACCUM  = 1'b0,
    COMMIT = 1'b1
  } state_e;
endpackage

// File: rtl/paddle_bbox_tracker_if.sv
// Pixel stream from the 5x5 denoise stage: enable, sync, valid, mask and centre coordinates.
interface paddle_bbox_tracker_if;
  import pong_pkg::*;

  logic   en_i;
  logic   vs_ni;
  logic   valid_i;
  logic   mask_i;
  coord_t row_i;
  coord_t col_i;

  modport master (output en_i, vs_ni, valid_i, mask_i, row_i, col_i);
  modport slave  (input  en_i, vs_ni, valid_i, mask_i, row_i, col_i);
endinterface

// File: rtl/paddle_bbox_tracker_bbox_accum.sv
// One region's running bounding box and saturating pixel count over a frame.
module bbox_accum
  import pong_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             clear,
  input  coord_t           row,
  input  coord_t           col,
  output bbox_t            bbox,
  output logic [CNT_W-1:0] count
);

  bbox_t            bbox_q, bbox_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over hit; the two never coincide because commit happens during sync.
  always_comb begin
    bbox_d  = bbox_q;
    count_d = count_q;
    if (clear) begin
      bbox_d  = BBOX_CLEAR;
      count_d = '0;
    end else if (hit) begin
      if (row < bbox_q.top)   bbox_d.top   = row;
      if (row > bbox_q.bot)   bbox_d.bot   = row;
      if (col < bbox_q.left)  bbox_d.left  = col;
      if (col > bbox_q.right) bbox_d.right = col;
      if (count_q != '1)      count_d      = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bbox_q  <= BBOX_CLEAR;
      count_q <= '0;
    end else begin
      bbox_q  <= bbox_d;
      count_q <= count_d;
    end
  end

  assign bbox  = bbox_q;
  assign count = count_q;
endmodule

// File: rtl/paddle_bbox_tracker.sv
// Per-frame bounding boxes of mask pixels for the left and right pong players.
module paddle_bbox_tracker
  import pong_pkg::*;
#(
  parameter int SPLIT_COL  = 320,
  parameter int MIN_PIXELS = 64,
  parameter int CNT_W      = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  paddle_bbox_tracker_if.slave   pix,
  output logic [COORD_W-1:0]     l_top_o,
  output logic [COORD_W-1:0]     l_bot_o,
  output logic [COORD_W-1:0]     l_left_o,
  output logic [COORD_W-1:0]     l_right_o,
  output logic [COORD_W-1:0]     r_top_o,
  output logic [COORD_W-1:0]     r_bot_o,
  output logic [COORD_W-1:0]     r_left_o,
  output logic [COORD_W-1:0]     r_right_o,
  output logic                   l_valid_o,
  output logic                   r_valid_o,
  output logic                   frame_done_o
);

  localparam coord_t      SPLIT   = coord_t'(SPLIT_COL);
  localparam logic [31:0] MIN_CNT = 32'(MIN_PIXELS);

  state_e           state_q;
  logic             vs_q;
  bbox_t            l_box_q, r_box_q;
  logic             l_valid_q, r_valid_q, done_q;
  bbox_t            l_acc, r_acc;
  logic [CNT_W-1:0] l_cnt, r_cnt;
  logic             hit, in_left, fall, clear, l_ok, r_ok;

  assign hit     = pix.en_i & pix.valid_i & pix.vs_ni & pix.mask_i;
  assign in_left = (pix.col_i < SPLIT);
  assign fall    = vs_q & ~pix.vs_ni;
  assign clear   = (state_q == COMMIT);
  assign l_ok    = (32'(l_cnt) >= MIN_CNT);
  assign r_ok    = (32'(r_cnt) >= MIN_CNT);

  bbox_accum #(.CNT_W(CNT_W)) u_left (
    .clk(clk), .rst(rst), .hit(hit & in_left), .clear(clear),
    .row(pix.row_i), .col(pix.col_i), .bbox(l_acc), .count(l_cnt)
  );

  bbox_accum #(.CNT_W(CNT_W)) u_right (
    .clk(clk), .rst(rst), .hit(hit & ~in_left), .clear(clear),
    .row(pix.row_i), .col(pix.col_i), .bbox(r_acc), .count(r_cnt)
  );

  // Under-populated regions keep their last good box so the overlay does not flicker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      vs_q      <= 1'b1;
      l_box_q   <= '0;
      r_box_q   <= '0;
      l_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      vs_q   <= pix.vs_ni;
      done_q <= 1'b0;
      case (state_q)
        ACCUM: if (fall) state_q <= COMMIT;
        COMMIT: begin
          state_q   <= ACCUM;
          done_q    <= 1'b1;
          l_valid_q <= l_ok;
          r_valid_q <= r_ok;
          if (l_ok) l_box_q <= l_acc;
          if (r_ok) r_box_q <= r_acc;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign l_top_o      = l_box_q.top;
  assign l_bot_o      = l_box_q.bot;
  assign l_left_o     = l_box_q.left;
  assign l_right_o    = l_box_q.right;
  assign r_top_o      = r_box_q.top;
  assign r_bot_o      = r_box_q.bot;
  assign r_left_o     = r_box_q.left;
  assign r_right_o    = r_box_q.right;
  assign l_valid_o    = l_valid_q;
  assign r_valid_o    = r_valid_q;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_paddle_bbox_tracker.sv
// Bench for paddle_bbox_tracker: two instances (MIN_PIXELS=2 wide counter, MIN_PIXELS=1 2-bit counter).
module tb_paddle_bbox_tracker;
  import pong_pkg::*;
  localparam int CW = COORD_W;

  typedef struct packed {
    logic [CW-1:0] lt, lb, ll, lr, rt, rb, rl, rr;
    logic          lv, rv;
  } box_t;

  typedef struct packed {
    int                  nh;
    logic [4:0][CW-1:0]  r;
    logic [4:0][CW-1:0]  c;
    logic [4:0][2:0]     g;   // {en, valid, mask}
    box_t                ea;  // instance A: MIN_PIXELS=2, CNT_W=20
    box_t                eb;  // instance B: MIN_PIXELS=1, CNT_W=2
  } vec_t;

  typedef struct {
    box_t ea;
    box_t eb;
    int   due;
    int   id;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;
  int nfr = 0;
  sb_t q[$];
  sb_t e;
  vec_t tbl[5];

  paddle_bbox_tracker_if pix();

  logic [CW-1:0] a_lt, a_lb, a_ll, a_lr, a_rt, a_rb, a_rl, a_rr;
  logic [CW-1:0] b_lt, b_lb, b_ll, b_lr, b_rt, b_rb, b_rl, b_rr;
  logic a_lv, a_rv, a_fd, b_lv, b_rv, b_fd;
  box_t obs_a, obs_b;
  assign obs_a = {a_lt, a_lb, a_ll, a_lr, a_rt, a_rb, a_rl, a_rr, a_lv, a_rv};
  assign obs_b = {b_lt, b_lb, b_ll, b_lr, b_rt, b_rb, b_rl, b_rr, b_lv, b_rv};

  paddle_bbox_tracker #(.SPLIT_COL(320), .MIN_PIXELS(2), .CNT_W(20)) dut_a (
    .clk(clk), .rst(rst), .pix(pix),
    .l_top_o(a_lt), .l_bot_o(a_lb), .l_left_o(a_ll), .l_right_o(a_lr),
    .r_top_o(a_rt), .r_bot_o(a_rb), .r_left_o(a_rl), .r_right_o(a_rr),
    .l_valid_o(a_lv), .r_valid_o(a_rv), .frame_done_o(a_fd)
  );

  paddle_bbox_tracker #(.SPLIT_COL(320), .MIN_PIXELS(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .pix(pix),
    .l_top_o(b_lt), .l_bot_o(b_lb), .l_left_o(b_ll), .l_right_o(b_lr),
    .r_top_o(b_rt), .r_bot_o(b_rb), .r_left_o(b_rl), .r_right_o(b_rr),
    .l_valid_o(b_lv), .r_valid_o(b_rv), .frame_done_o(b_fd)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic box_t mk(input int lt, lb, ll, lr, rt, rb, rl, rr, input logic lv, rv);
    box_t b;
    b.lt = CW'(lt); b.lb = CW'(lb); b.ll = CW'(ll); b.lr = CW'(lr);
    b.rt = CW'(rt); b.rb = CW'(rb); b.rl = CW'(rl); b.rr = CW'(rr);
    b.lv = lv; b.rv = rv;
    return b;
  endfunction

  function automatic vec_t add(input vec_t v, input int r, input int c, input logic [2:0] g);
    v.r[v.nh] = CW'(r);
    v.c[v.nh] = CW'(c);
    v.g[v.nh] = g;
    v.nh = v.nh + 1;
    return v;
  endfunction

  function automatic void set_pix(input logic en, valid, vsn, mask, input int r, input int c);
    pix.en_i    = en;
    pix.valid_i = valid;
    pix.vs_ni   = vsn;
    pix.mask_i  = mask;
    pix.row_i   = CW'(r);
    pix.col_i   = CW'(c);
  endfunction

  task automatic drive(input logic en, valid, vsn, mask, input int r, input int c);
    @(posedge clk); #1;
    set_pix(en, valid, vsn, mask, r, c);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  // Must be called in the same step vs_ni is first driven low.
  task automatic expect_commit(input box_t ea, input box_t eb);
    q.push_back('{ea: ea, eb: eb, due: cyc + 2, id: nfr});
    nfr++;
  endtask

  task automatic frame_end(input box_t ea, input box_t eb, input logic vmask);
    @(posedge clk); #1;
    set_pix(vmask, vmask, 1'b0, vmask, 3, 3);
    expect_commit(ea, eb);
    repeat (3) drive(vmask, vmask, 1'b0, vmask, 3, 3);
    idle(3);
  endtask

  always @(negedge clk) begin
    if (a_fd || b_fd) begin
      if (q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL spurious_done: got a=%0b b=%0b at cycle %0d required no pulse", a_fd, b_fd, cyc);
      end else begin
        e = q.pop_front();
        check($sformatf("f%0d done_a", e.id), 128'(a_fd), 128'(1));
        check($sformatf("f%0d done_b", e.id), 128'(b_fd), 128'(1));
        check($sformatf("f%0d latency", e.id), 128'(cyc), 128'(e.due));
        check($sformatf("f%0d box_a", e.id), 128'(obs_a), 128'(e.ea));
        check($sformatf("f%0d box_b", e.id), 128'(obs_b), 128'(e.eb));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    set_pix(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // Frame 0: two left hits -> full left box.
    t = '0;
    t = add(t, 100, 50, 3'b111);
    t = add(t, 120, 80, 3'b111);
    t.ea = mk(100, 120, 50, 80, 0, 0, 0, 0, 1'b1, 1'b0);
    t.eb = mk(100, 120, 50, 80, 0, 0, 0, 0, 1'b1, 1'b0);
    tbl[0] = t;
    // Frame 1: one hit, below threshold for A only.
    t = '0;
    t = add(t, 10, 10, 3'b111);
    t.ea = mk(100, 120, 50, 80, 0, 0, 0, 0, 1'b0, 1'b0);
    t.eb = mk(10, 10, 10, 10, 0, 0, 0, 0, 1'b1, 1'b0);
    tbl[1] = t;
    // Frame 2: split boundary columns 319 / 320.
    t = '0;
    t = add(t, 30, 319, 3'b111);
    t = add(t, 40, 320, 3'b111);
    t = add(t, 35, 319, 3'b111);
    t = add(t, 45, 320, 3'b111);
    t.ea = mk(30, 35, 319, 319, 40, 45, 320, 320, 1'b1, 1'b1);
    t.eb = mk(30, 35, 319, 319, 40, 45, 320, 320, 1'b1, 1'b1);
    tbl[2] = t;
    // Frame 3: every pixel gated by en, valid or mask.
    t = '0;
    t = add(t, 7, 7, 3'b011);
    t = add(t, 8, 400, 3'b101);
    t = add(t, 9, 9, 3'b110);
    t = add(t, 9, 500, 3'b011);
    t.ea = mk(30, 35, 319, 319, 40, 45, 320, 320, 1'b0, 1'b0);
    t.eb = mk(30, 35, 319, 319, 40, 45, 320, 320, 1'b0, 1'b0);
    tbl[3] = t;
    // Frame 4: five hits; B's 2-bit counter saturates but its box keeps growing.
    t = '0;
    t = add(t, 60, 100, 3'b111);
    t = add(t, 61, 90, 3'b111);
    t = add(t, 62, 110, 3'b111);
    t = add(t, 59, 95, 3'b111);
    t = add(t, 70, 120, 3'b111);
    t.ea = mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b1, 1'b0);
    t.eb = mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b1, 1'b0);
    tbl[4] = t;

    #12;
    check("reset_box_a", 128'(obs_a), 128'(0));
    check("reset_box_b", 128'(obs_b), 128'(0));
    check("reset_done", 128'({a_fd, b_fd}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      for (int h = 0; h < tbl[i].nh; h++)
        drive(tbl[i].g[h][2], tbl[i].g[h][1], 1'b1, tbl[i].g[h][0],
              int'(tbl[i].r[h]), int'(tbl[i].c[h]));
      frame_end(tbl[i].ea, tbl[i].eb, 1'b0);
    end

    // Mask pixels while vs_ni is low (including the fall and commit cycles) must not count.
    idle(2);
    frame_end(mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b0, 1'b0),
              mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b0, 1'b0), 1'b1);
    idle(2);
    frame_end(mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b0, 1'b0),
              mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b0, 1'b0), 1'b0);

    // Glitching vs_ni: two falls two cycles apart give two commits.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1, 2);
    idle(1);
    @(posedge clk); #1;
    set_pix(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    expect_commit(mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b0, 1'b0),
                  mk(1, 1, 2, 2, 40, 45, 320, 320, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    @(posedge clk); #1;
    set_pix(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    expect_commit(mk(59, 70, 90, 120, 40, 45, 320, 320, 1'b0, 1'b0),
                  mk(1, 1, 2, 2, 40, 45, 320, 320, 1'b0, 1'b0));
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(3);

    // Asynchronous reset mid-frame discards the partial frame.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5, 5);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 200, 200);
    @(posedge clk); #1;
    set_pix(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", 128'(obs_a), 128'(0));
    check("async_rst_b", 128'(obs_b), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 50, 60);
    idle(1);
    frame_end(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0),
              mk(50, 50, 60, 60, 0, 0, 0, 0, 1'b1, 1'b0), 1'b0);

    idle(3);
    check("sb_drain", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/paddle_bbox_tracker.md
# paddle_bbox_tracker

Downstream stage of the 5×5 denoise/convolution kernel. It consumes the filtered binary mask together with the centre-aligned row/col, valid and vertical-sync signals. Over each video frame it accumulates the bounding box of mask pixels in two column regions, one per pong player. At frame end it commits each box to registered outputs that feed the rectangle overlay and the game logic.

## Interface
Parameters:
- `COORD_W`, 13: width of row/col coordinates and box outputs.
- `SPLIT_COL`, 320: first column of the right-player region; `col < SPLIT_COL` is the left region.
- `MIN_PIXELS`, 64: minimum mask-pixel count for a region's box to be committed as valid.
- `CNT_W`, 20: width of the per-region pixel counter.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  stage enable; when low, no accumulation occurs. Edge detection still runs.
- `vs_ni`  in  1  vertical sync, active low, aligned with `mask_i`.
- `valid_i`  in  1  pixel-valid flag, aligned with `mask_i`.
- `mask_i`  in  1  denoised mask bit; 1 = object pixel.
- `row_i`  in  COORD_W  row of the current pixel.
- `col_i`  in  COORD_W  column of the current pixel.
- `l_top_o`, `l_bot_o`, `l_left_o`, `l_right_o`  out  COORD_W each  committed left-region box.
- `r_top_o`, `r_bot_o`, `r_left_o`, `r_right_o`  out  COORD_W each  committed right-region box.
- `l_valid_o`, `r_valid_o`  out  1  the last commit for that region met `MIN_PIXELS`.
- `frame_done_o`  out  1  one-cycle pulse marking a commit.

## Operation
- Hit condition: `en_i & valid_i & vs_ni & mask_i`. A hit goes to the left region if `col_i < SPLIT_COL`, otherwise to the right region.
- Per-region accumulators: `min_row`, `max_row`, `min_col`, `max_col`, `count`.
  - Cleared state: mins = all ones, maxes = 0, count = 0.
  - On a hit: each min/max is updated by unsigned compare.
  - `count` increments and saturates at all ones.
- Frame end is the falling edge of `vs_ni`, detected against the registered `vs_d`: `fall = vs_d & ~vs_ni`.
- Two-state FSM:
  - `ACCUM`: accumulate hits. On `fall`, move to `COMMIT`.
  - `COMMIT`: one cycle. For each region:
    - If `count >= MIN_PIXELS`: load box outputs as top = `min_row`, bot = `max_row`, left = `min_col`, right = `max_col`, and set `*_valid_o` = 1.
    - Otherwise: box outputs hold their previous values and `*_valid_o` = 0.
    - In both cases, clear the accumulators, pulse `frame_done_o`, and return to `ACCUM`.
- `COMMIT` occurs while `vs_ni` is low, so no hit can be lost in that cycle.
- Every box output is a register; outputs change only in `COMMIT` or on reset.
- A region with zero hits never commits its all-ones/zero sentinels, because a count of 0 is always below `MIN_PIXELS` (MIN_PIXELS ≥ 1 is required).

## Timing
- Reset (asynchronous, immediate):
  - All box outputs = 0.
  - `l_valid_o` = `r_valid_o` = 0, `frame_done_o` = 0.
  - Accumulators cleared, `vs_d` = 1, FSM in `ACCUM`.
- Latency: the `fall` cycle is edge N. Outputs and the `frame_done_o` pulse are visible after edge N+1 and last exactly one cycle.
- Accumulator updates take effect on the next clock edge after the hit.
- A second `fall` cannot occur within 2 cycles in legal video. If `vs_ni` glitches, each detected fall produces its own commit.
- Reset mid-frame: the partial frame is discarded and nothing is committed. The first commit after reset covers only the hits that follow reset.
- Counter saturation: `count` holds at `2^CNT_W - 1`, and the box keeps updating.

## Structure
- Shared package `pong_pkg`:
  - `COORD_W`.
  - `bbox_t` struct {top, bot, left, right}.
  - `BBOX_CLEAR` constant (mins all ones, maxes 0).
  - The FSM state enum.
- Sub-module `bbox_accum`, instantiated twice: one region's accumulator with inputs `clk`, `rst`, `hit`, `clear`, `row`, `col`; outputs `bbox_t` and `count`.
- The top level owns:
  - the edge detector,
  - the FSM,
  - the region split,
  - the output registers.

## Test plan
- Reset: assert `rst` mid-clock → all outputs 0 immediately, without waiting for a clock edge.
- Left box, `MIN_PIXELS`=2: hits at (row 100, col 50) and (120, 80), then `vs_ni` falls → two cycles later `l_top`=100, `l_bot`=120, `l_left`=50, `l_right`=80, `l_valid`=1, one `frame_done_o` pulse; right outputs 0 with `r_valid`=0.
- Threshold: the next frame has one left hit at (10, 10) → left box still 100/120/50/80, `l_valid`=0.
- Split boundary: hits at `col`=`SPLIT_COL`-1 and `col`=`SPLIT_COL` → the first lands only in the left box, the second only in the right box.
- Gating: a mask pixel with `valid_i`=0, with `en_i`=0, or with `vs_ni`=0 → not counted; with `MIN_PIXELS`=1 the region stays invalid.
- Reset mid-frame: hits at (5, 5) and (200, 200), `rst` pulse, a hit at (50, 60), then `vs_ni` falls → `l_top`=50, `l_bot`=50, `l_left`=60, `l_right`=60.
